// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE-array control sequencer.
package pe_ctrl_pkg;

    localparam int N_PE_DEF      = 8;
    localparam int ADDR_FIFO_DEF = 8;
    localparam int W_CNT_DEF     = 10;

    typedef enum logic [2:0] {
        IDLE,
        LBRST,
        FLOAD,
        COMPUTE,
        DONE
    } pe_state_t;

    // Flat bit position of PE (r, c) inside an n x n grid vector.
    function automatic int idx(input int r, input int c, input int n = N_PE_DEF);
        return r * n + c;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_seq_if.sv
// Input-stream handshake plus the control bundle consumed by the PE array.
interface pe_array_ctrl_seq_if
    import pe_ctrl_pkg::*;
#(
    parameter int N_PE      = N_PE_DEF,
    parameter int ADDR_FIFO = ADDR_FIFO_DEF
);

    // A word moves on every cycle where in_valid && in_ready; in_ready never waits on in_valid.
    logic                      in_valid;
    logic                      in_ready;
    logic [N_PE*N_PE-1:0]      shifting_line;
    logic [N_PE*N_PE-1:0]      shifting_filter;
    logic [N_PE*N_PE-1:0]      mac_enable;
    logic [N_PE-1:0]           nl_enable;
    logic [N_PE-1:0]           feedback_enable;
    logic [N_PE-1:0]           adder_enable;
    logic                      line_buffer_reset;
    logic [ADDR_FIFO-1:0]      row_length;
    logic                      final_filter_bank;

    modport master (
        input  in_valid,
        output in_ready,
        output shifting_line, shifting_filter, mac_enable,
        output nl_enable, feedback_enable, adder_enable,
        output line_buffer_reset, row_length, final_filter_bank
    );

    modport slave (
        output in_valid,
        input  in_ready,
        input  shifting_line, shifting_filter, mac_enable,
        input  nl_enable, feedback_enable, adder_enable,
        input  line_buffer_reset, row_length, final_filter_bank
    );

endinterface

// File: rtl/pe_ctrl_mask_gen.sv
// Kernel-size to active-PE mask: grid bit (r,c) set when r<k and c<k, column bit c set when c<k.
module pe_ctrl_mask_gen
    import pe_ctrl_pkg::*;
#(
    parameter int N_PE = N_PE_DEF,
    localparam int KW  = $clog2(N_PE + 1)
) (
    input  logic [KW-1:0]          k,
    output logic [N_PE*N_PE-1:0]   grid_mask,
    output logic [N_PE-1:0]        col_mask
);

    for (genvar r = 0; r < N_PE; r++) begin : g_row
        assign col_mask[r] = (int'(k) > r);
        for (genvar c = 0; c < N_PE; c++) begin : g_col
            assign grid_mask[idx(r, c, N_PE)] = (int'(k) > r) && (int'(k) > c);
        end
    end

endmodule

// File: rtl/pe_array_ctrl_seq.sv
// Sequences one convolution layer: line-buffer reset, k*k filter load, then row shifting
// with MAC windowing, repeated per filter bank. All array controls are registered.
module pe_array_ctrl_seq
    import pe_ctrl_pkg::*;
#(
    parameter int N_PE      = N_PE_DEF,
    parameter int ADDR_FIFO = ADDR_FIFO_DEF,
    parameter int W_CNT     = W_CNT_DEF,
    localparam int KW       = $clog2(N_PE + 1),
    localparam int NG       = N_PE * N_PE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KW-1:0]         cfg_k,
    input  logic [ADDR_FIFO-1:0]  cfg_row_length,
    input  logic [W_CNT-1:0]      cfg_num_rows,
    input  logic [W_CNT-1:0]      cfg_num_banks,
    pe_array_ctrl_seq_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output pe_state_t             dbg_state
);

    pe_state_t state, next_state;

    logic [KW-1:0]        k_q;
    logic [ADDR_FIFO-1:0] rl_q;
    logic [W_CNT-1:0]     nr_q, nb_q;
    logic [W_CNT-1:0]     beat_cnt, row_cnt, bank_cnt;
    logic [ADDR_FIFO-1:0] col_cnt;

    logic [NG-1:0]   grid_mask;
    logic [N_PE-1:0] col_mask;

    logic [NG-1:0]   sl_q, sf_q, mac_q;
    logic [N_PE-1:0] nl_q, fb_q, add_q;
    logic            lbr_q, ffb_q, busy_q, done_q, cfg_err_q;

    logic [NG-1:0]   sl_d, sf_d, mac_d;
    logic [N_PE-1:0] nl_d, fb_d, add_d;
    logic            lbr_d, ffb_d, busy_d, done_d, cfg_err_d;

    logic            cfg_ok, accept, beat, mac_beat;
    logic            last_filter, last_col, last_row, last_bank, full_win;
    logic [W_CNT-1:0] kk;

    pe_ctrl_mask_gen #(.N_PE(N_PE)) u_mask (
        .k         (k_q),
        .grid_mask (grid_mask),
        .col_mask  (col_mask)
    );

    assign cfg_ok = (cfg_k != '0) && (int'(cfg_k) <= N_PE) &&
                    (cfg_row_length >= ADDR_FIFO'(cfg_k)) &&
                    (cfg_num_rows != '0) && (cfg_num_banks != '0);
    assign accept = (state == IDLE) && start && !abort && cfg_ok;

    assign bus.in_ready = (state == FLOAD) || (state == COMPUTE);
    assign beat         = bus.in_valid && bus.in_ready;

    assign kk          = W_CNT'(k_q) * W_CNT'(k_q);
    assign last_filter = (beat_cnt == kk - W_CNT'(1));
    assign last_col    = (col_cnt == rl_q - ADDR_FIFO'(1));
    assign last_row    = (row_cnt == nr_q - W_CNT'(1));
    assign last_bank   = (bank_cnt == nb_q - W_CNT'(1));
    // A MAC window is complete once k pixels of the current row have been shifted in.
    assign full_win    = (col_cnt >= ADDR_FIFO'(k_q) - ADDR_FIFO'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) next_state = LBRST;
                LBRST:   next_state = FLOAD;
                FLOAD:   if (beat && last_filter) next_state = COMPUTE;
                COMPUTE: if (beat && last_col && last_row) next_state = last_bank ? DONE : LBRST;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        sl_d      = '0;
        sf_d      = '0;
        mac_d     = '0;
        nl_d      = '0;
        fb_d      = '0;
        add_d     = '0;
        mac_beat  = (state == COMPUTE) && beat && full_win;
        lbr_d     = (next_state == LBRST);
        busy_d    = (next_state != IDLE);
        done_d    = (next_state == DONE);
        cfg_err_d = (state == IDLE) && start && !abort && !cfg_ok;
        if ((state == FLOAD) && beat) sf_d = grid_mask;
        if ((state == COMPUTE) && beat) sl_d = grid_mask;
        if (mac_beat) begin
            mac_d = grid_mask;
            add_d = col_mask;
            if (bank_cnt != '0) fb_d = col_mask;
            if (last_bank) nl_d = col_mask;
        end
        // The final-bank flag follows the bank that the next state belongs to.
        if (next_state == IDLE) begin
            ffb_d = 1'b0;
        end else if (state == IDLE) begin
            ffb_d = (cfg_num_banks == W_CNT'(1));
        end else if ((state == COMPUTE) && (next_state == LBRST)) begin
            ffb_d = (bank_cnt + W_CNT'(1) == nb_q - W_CNT'(1));
        end else begin
            ffb_d = last_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0; rl_q <= '0; nr_q <= '0; nb_q <= '0;
            beat_cnt <= '0; col_cnt <= '0; row_cnt <= '0; bank_cnt <= '0;
            sl_q <= '0; sf_q <= '0; mac_q <= '0;
            nl_q <= '0; fb_q <= '0; add_q <= '0;
            lbr_q <= 1'b0; ffb_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; cfg_err_q <= 1'b0;
        end else if (abort) begin
            k_q <= '0; rl_q <= '0; nr_q <= '0; nb_q <= '0;
            beat_cnt <= '0; col_cnt <= '0; row_cnt <= '0; bank_cnt <= '0;
            sl_q <= '0; sf_q <= '0; mac_q <= '0;
            nl_q <= '0; fb_q <= '0; add_q <= '0;
            lbr_q <= 1'b0; ffb_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; cfg_err_q <= 1'b0;
        end else begin
            sl_q <= sl_d; sf_q <= sf_d; mac_q <= mac_d;
            nl_q <= nl_d; fb_q <= fb_d; add_q <= add_d;
            lbr_q <= lbr_d; ffb_q <= ffb_d; busy_q <= busy_d; done_q <= done_d; cfg_err_q <= cfg_err_d;
            if (accept) begin
                k_q      <= cfg_k;
                rl_q     <= cfg_row_length;
                nr_q     <= cfg_num_rows;
                nb_q     <= cfg_num_banks;
                beat_cnt <= '0;
                col_cnt  <= '0;
                row_cnt  <= '0;
                bank_cnt <= '0;
            end else if ((state == FLOAD) && beat) begin
                if (last_filter) begin
                    beat_cnt <= '0;
                    col_cnt  <= '0;
                    row_cnt  <= '0;
                end else begin
                    beat_cnt <= beat_cnt + W_CNT'(1);
                end
            end else if ((state == COMPUTE) && beat) begin
                if (last_col) begin
                    col_cnt <= '0;
                    if (last_row) begin
                        row_cnt <= '0;
                        if (!last_bank) bank_cnt <= bank_cnt + W_CNT'(1);
                    end else begin
                        row_cnt <= row_cnt + W_CNT'(1);
                    end
                end else begin
                    col_cnt <= col_cnt + ADDR_FIFO'(1);
                end
            end
        end
    end

    assign bus.shifting_line     = sl_q;
    assign bus.shifting_filter   = sf_q;
    assign bus.mac_enable        = mac_q;
    assign bus.nl_enable         = nl_q;
    assign bus.feedback_enable   = fb_q;
    assign bus.adder_enable      = add_q;
    assign bus.line_buffer_reset = lbr_q;
    assign bus.row_length        = rl_q;
    assign bus.final_filter_bank = ffb_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign cfg_err               = cfg_err_q;
    assign dbg_state             = state;

endmodule

// File: tb/tb_pe_array_ctrl_seq.sv
// Scoreboard bench for pe_array_ctrl_seq with a 4x4 grid: directed layer runs, stalls, bad configs, abort, reset.
module tb_pe_array_ctrl_seq;
    import pe_ctrl_pkg::*;

    localparam int N_PE      = 4;
    localparam int ADDR_FIFO = 8;
    localparam int W_CNT     = 10;
    localparam int KW        = $clog2(N_PE + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [KW-1:0]        cfg_k = '0;
    logic [ADDR_FIFO-1:0] cfg_row_length = '0;
    logic [W_CNT-1:0]     cfg_num_rows = '0;
    logic [W_CNT-1:0]     cfg_num_banks = '0;
    logic busy, done, cfg_err;
    pe_state_t dbg_state;

    pe_array_ctrl_seq_if #(.N_PE(N_PE), .ADDR_FIFO(ADDR_FIFO)) bus ();

    pe_array_ctrl_seq #(.N_PE(N_PE), .ADDR_FIFO(ADDR_FIFO), .W_CNT(W_CNT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_k          (cfg_k),
        .cfg_row_length (cfg_row_length),
        .cfg_num_rows   (cfg_num_rows),
        .cfg_num_banks  (cfg_num_banks),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int   cyc = 0;
    logic v_edge = 1'b0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        v_edge <= bus.in_valid;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        lbr;
        logic [15:0] sf;
        logic [15:0] sl;
        logic [15:0] mac;
        logic [3:0]  nl;
        logic [3:0]  fb;
        logic [3:0]  add;
        logic        ffb;
        logic        done;
        logic        cfg_err;
        logic        busy;
    } snap_t;
    localparam int SW = $bits(snap_t);

    logic [SW-1:0] exp_q[$];
    int            off_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  start_cyc = 0;
    bit  sb_en = 1'b0;
    bit  chk_stall = 1'b0;
    int  mac_seen = 0, sl_seen = 0, lbr_seen = 0, done_seen = 0;

    function automatic snap_t cur_snap();
        snap_t s;
        s.lbr     = bus.line_buffer_reset;
        s.sf      = bus.shifting_filter;
        s.sl      = bus.shifting_line;
        s.mac     = bus.mac_enable;
        s.nl      = bus.nl_enable;
        s.fb      = bus.feedback_enable;
        s.add     = bus.adder_enable;
        s.ffb     = bus.final_filter_bank;
        s.done    = done;
        s.cfg_err = cfg_err;
        s.busy    = busy;
        return s;
    endfunction

    function automatic logic [127:0] all_outputs();
        return {bus.line_buffer_reset, bus.shifting_filter, bus.shifting_line, bus.mac_enable,
                bus.nl_enable, bus.feedback_enable, bus.adder_enable, bus.final_filter_bank,
                bus.row_length, bus.in_ready, done, busy, cfg_err};
    endfunction

    // Monitor: every cycle with array activity pops one expected snapshot.
    always @(negedge clk) begin
        snap_t         s;
        logic [SW-1:0] e;
        int            o;
        s = cur_snap();
        if (rst_n) begin
            if (s.mac != '0) mac_seen++;
            if (s.sl != '0)  sl_seen++;
            if (s.lbr)       lbr_seen++;
            if (s.done)      done_seen++;
            if (sb_en && (s.lbr || s.sf != '0 || s.sl != '0 || s.mac != '0 || s.done || s.cfg_err)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got %h exp none (cycle %0d)", s, cyc);
                end else begin
                    e = exp_q.pop_front();
                    o = off_q.pop_front();
                    if (s !== e) begin
                        n_fail++;
                        $display("FAIL sb_event got %h exp %h (cycle %0d)", s, e, cyc);
                    end
                    if (o >= 0) begin
                        n_cmp++;
                        if (cyc - start_cyc != o) begin
                            n_fail++;
                            $display("FAIL sb_timing got offset %0d exp %0d", cyc - start_cyc, o);
                        end
                    end
                end
            end
            if (chk_stall && !v_edge) begin
                n_cmp++;
                if ({s.sf, s.sl, s.mac, s.nl, s.fb, s.add} != '0) begin
                    n_fail++;
                    $display("FAIL stall_zero got %h exp 0 (cycle %0d)", s, cyc);
                end
            end
        end
    end

    // ---------------- driver / helper tasks ----------------
    task automatic push(input snap_t s, input int off);
        exp_q.push_back(s);
        off_q.push_back(off);
    endtask

    // Expected activity of a k=3, row_length=5, num_rows=2 layer on a 4x4 grid.
    task automatic push_run(input int nb, input bit timed);
        snap_t s;
        bit    fin;
        for (int b = 0; b < nb; b++) begin
            fin = (b == nb - 1);
            if (b == 0) begin
                s = '0; s.lbr = 1'b1; s.busy = 1'b1; s.ffb = fin;
                push(s, timed ? 1 : -1);
            end
            for (int i = 0; i < 9; i++) begin
                s = '0; s.sf = 16'h0777; s.busy = 1'b1; s.ffb = fin;
                push(s, -1);
            end
            for (int row = 0; row < 2; row++) begin
                for (int col = 0; col < 5; col++) begin
                    s = '0; s.sl = 16'h0777; s.busy = 1'b1; s.ffb = fin;
                    if (col >= 2) begin
                        s.mac = 16'h0777;
                        s.add = 4'h7;
                        s.fb  = (b > 0) ? 4'h7 : 4'h0;
                        s.nl  = fin ? 4'h7 : 4'h0;
                    end
                    if (row == 1 && col == 4) begin
                        if (!fin) begin
                            s.lbr = 1'b1;
                            s.ffb = (b + 1 == nb - 1);
                        end else begin
                            s.done = 1'b1;
                        end
                    end
                    push(s, (timed && fin && row == 1 && col == 4) ? 21 : -1);
                end
            end
        end
    endtask

    task automatic do_start(input int k, input int rl, input int nr, input int nb);
        @(negedge clk);
        cfg_k          = KW'(k);
        cfg_row_length = ADDR_FIFO'(rl);
        cfg_num_rows   = W_CNT'(nr);
        cfg_num_banks  = W_CNT'(nb);
        start          = 1'b1;
        start_cyc      = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy && dbg_state == IDLE) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout got busy %0d exp idle", name, busy);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (2) @(negedge clk);
        check_vec({name, "_drained"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        off_q.delete();
    endtask

    task automatic clear_counts();
        mac_seen = 0; sl_seen = 0; lbr_seen = 0; done_seen = 0;
    endtask

    // ---------------- stimulus ----------------
    int bad_k[4]  = '{0, 5, 3, 3};
    int bad_rl[4] = '{5, 5, 2, 5};
    int bad_nb[4] = '{1, 1, 1, 0};

    initial begin
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset_outputs", all_outputs(), 128'd0);
        check_vec("reset_state", 128'(dbg_state), 128'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        sb_en = 1'b1;

        // single bank, continuous input
        clear_counts();
        bus.in_valid = 1'b1;
        push_run(1, 1'b1);
        do_start(3, 5, 2, 1);
        check_vec("row_length_latched", 128'(bus.row_length), 128'd5);
        wait_idle("run1");
        drain_check("run1");
        check_vec("run1_mac_beats", 128'(mac_seen), 128'd6);
        check_vec("run1_shift_beats", 128'(sl_seen), 128'd10);
        check_vec("run1_lbr_pulses", 128'(lbr_seen), 128'd1);
        check_vec("row_length_held", 128'(bus.row_length), 128'd5);

        // three banks
        clear_counts();
        push_run(3, 1'b0);
        do_start(3, 5, 2, 3);
        wait_idle("run3");
        drain_check("run3");
        check_vec("run3_mac_beats", 128'(mac_seen), 128'd18);
        check_vec("run3_lbr_pulses", 128'(lbr_seen), 128'd3);

        // in_valid toggling every cycle
        clear_counts();
        push_run(1, 1'b0);
        bus.in_valid = 1'b1;
        chk_stall = 1'b1;
        do_start(3, 5, 2, 1);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
                @(negedge clk);
                bus.in_valid = ~bus.in_valid;
                if (!busy && dbg_state == IDLE) ok = 1'b1;
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_timeout got busy %0d exp idle", busy);
            end
        end
        chk_stall = 1'b0;
        bus.in_valid = 1'b0;
        drain_check("stall");
        check_vec("stall_mac_beats", 128'(mac_seen), 128'd6);
        check_vec("stall_shift_beats", 128'(sl_seen), 128'd10);

        // invalid configurations
        for (int t = 0; t < 4; t++) begin
            snap_t s;
            clear_counts();
            s = '0;
            s.cfg_err = 1'b1;
            push(s, 1);
            do_start(bad_k[t], bad_rl[t], 2, bad_nb[t]);
            drain_check("cfg_err");
            check_vec("cfg_err_busy", 128'(busy), 128'd0);
            check_vec("cfg_err_state", 128'(dbg_state), 128'(IDLE));
            check_vec("cfg_err_lbr", 128'(lbr_seen), 128'd0);
        end

        // abort mid-COMPUTE of bank 1, with start also high
        sb_en = 1'b0;
        bus.in_valid = 1'b1;
        do_start(3, 5, 2, 3);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
                @(negedge clk);
                if (dbg_state == COMPUTE && bus.feedback_enable != '0) ok = 1'b1;
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL abort_reach_bank1 got state %0d exp COMPUTE", dbg_state);
            end
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_vec("abort_outputs", all_outputs() & ~128'(4'b1000 << 3), 128'd0);
        check_vec("abort_in_ready", 128'(bus.in_ready), 128'd0);
        check_vec("abort_state", 128'(dbg_state), 128'(IDLE));
        done_seen = 0;
        repeat (30) @(negedge clk);
        check_vec("abort_no_done", 128'(done_seen), 128'd0);
        check_vec("abort_stays_idle", 128'(dbg_state), 128'(IDLE));

        sb_en = 1'b1;
        clear_counts();
        push_run(1, 1'b1);
        do_start(3, 5, 2, 1);
        wait_idle("post_abort");
        drain_check("post_abort");
        check_vec("post_abort_mac_beats", 128'(mac_seen), 128'd6);

        // asynchronous reset mid-FLOAD
        sb_en = 1'b0;
        do_start(3, 5, 2, 1);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (dbg_state == FLOAD && bus.shifting_filter != '0) ok = 1'b1;
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rst_reach_fload got state %0d exp FLOAD", dbg_state);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_rst_outputs", all_outputs(), 128'd0);
        check_vec("async_rst_state", 128'(dbg_state), 128'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_vec("post_rst_idle", 128'(dbg_state), 128'(IDLE));
        check_vec("post_rst_outputs", all_outputs() & ~128'(4'b1000 << 3), 128'd0);

        sb_en = 1'b1;
        clear_counts();
        push_run(1, 1'b1);
        do_start(3, 5, 2, 1);
        wait_idle("post_rst");
        drain_check("post_rst");
        check_vec("post_rst_mac_beats", 128'(mac_seen), 128'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_array_ctrl_seq.md
Name: pe_array_ctrl_seq

Overview:
- Drives the PE-array control bundle (shifting_line, shifting_filter, mac_enable, nl_enable, feedback_enable, adder_enable, line_buffer_reset, row_length, final_filter_bank) that the PE array consumes.
- Sequences one convolution layer: filter load, then row-by-row line shifting with MAC windowing, repeated per filter bank.
- Sits between the layer controller (start/config) and the PE array. It is paced by an input-stream valid from the data buffer.

Parameters:
- N_PE, 8: PE grid dimension (N_PE x N_PE).
- ADDR_FIFO, 8: row_length width.
- W_CNT, 10: row and bank counter width.

Ports:
- clk in 1: clock
- rst_n in 1: reset, asynchronous assert, active-low
- start in 1: start pulse, accepted only in IDLE
- abort in 1: synchronous abort
- cfg_k in $clog2(N_PE+1): kernel size, 1..N_PE
- cfg_row_length in ADDR_FIFO: pixels per input row
- cfg_num_rows in W_CNT: input rows per bank
- cfg_num_banks in W_CNT: filter banks
- in_valid in 1: input/filter word available this cycle
- in_ready out 1: block consumes a word this cycle
- shifting_line out N_PE*N_PE: bit r*N_PE+c is for PE row r, column c
- shifting_filter out N_PE*N_PE: same indexing
- mac_enable out N_PE*N_PE: same indexing
- nl_enable out N_PE: per column
- feedback_enable out N_PE: per column
- adder_enable out N_PE: per column
- line_buffer_reset out 1
- row_length out ADDR_FIFO: latched cfg_row_length
- final_filter_bank out 1
- busy out 1
- done out 1: one-cycle pulse
- cfg_err out 1: one-cycle pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Active mask: act(r,c) = (r<k)&&(c<k). All per-PE outputs are gated by the mask. act_col(c) = c<k.
- States:
  - IDLE → LBRST on start with valid config. Config is latched on acceptance.
  - LBRST: line_buffer_reset=1 for exactly 1 cycle, then FLOAD.
  - FLOAD: filter load, k*k beats.
  - COMPUTE: row processing.
  - DONE: done=1 for 1 cycle, then IDLE.
- Invalid config (k==0, k>N_PE, row_length<k, num_rows==0 or num_banks==0): start is ignored, cfg_err=1 the next cycle, state stays IDLE.
- FLOAD:
  - in_ready=1.
  - On each in_valid beat, shifting_filter=mask; beat counter advances.
  - After k*k beats: col_cnt=0, row_cnt=0, go to COMPUTE.
- COMPUTE:
  - in_ready=1.
  - On each in_valid beat, shifting_line=mask.
  - mac_enable=mask and adder_enable=act_col only when col_cnt>=k-1 (full window).
  - feedback_enable=act_col on MAC beats when bank_cnt>0.
  - nl_enable=act_col on MAC beats when final_filter_bank.
  - col_cnt wraps at row_length-1, then row_cnt increments.
  - At the end of the last row: if bank_cnt<num_banks-1, bank_cnt++ and go to LBRST; else go to DONE.
- in_valid=0 stall: every shift/mac/enable output is 0 that cycle and all counters hold. There is no timeout.
- final_filter_bank = (bank_cnt==num_banks-1), held throughout the bank.
- busy=1 in every state except IDLE. row_length holds its latched value until the next accepted start.
- abort: has priority over everything including start. Next cycle: IDLE, all outputs 0, no done pulse.
- start while busy is ignored.
- Outputs are registered: an enable is visible on the clock edge after the beat that qualifies it. in_ready is combinational from state. A word is consumed when in_valid && in_ready.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - state enum (IDLE, LBRST, FLOAD, COMPUTE, DONE)
  - mask-index helper function idx(r,c)=r*N_PE+c
  - the N_PE and ADDR_FIFO defaults
- Sub-module pe_ctrl_mask_gen: combinational generation of the k→grid mask and the column mask, reused for all three grid outputs.

Test Plan:
- N_PE=4, k=3, row_length=5, num_rows=2, banks=1, in_valid=1 constantly:
  - line_buffer_reset at cycle 1
  - 9 filter beats with shifting_filter=0x0777
  - 10 shift beats
  - exactly 6 mac_enable=0x0777 beats (3 per row)
  - nl_enable=0x7 on those beats
  - done 1 cycle after the last beat, i.e. cycle 21 from start
- Same config with banks=3:
  - 3 LBRST pulses
  - feedback_enable=0 in bank 0 and =0x7 in banks 1–2
  - final_filter_bank high only in bank 2
  - 18 total MAC beats
- in_valid toggling 1,0,1,0 during COMPUTE: outputs are 0 on every low cycle; MAC and shift counts match the uninterrupted run.
- Configs with k=0, k=5, row_length=2 with k=3, and banks=0: each gives a cfg_err pulse, busy stays 0, no output activity.
- abort asserted mid-COMPUTE of bank 1 (with start also high): all outputs 0 next cycle, no done pulse, state IDLE. A following start runs normally.
- rst_n low mid-FLOAD: all outputs 0 immediately (asynchronous). After release the block is IDLE and requires a new start.
